mor1kx_dpram_fifo_ctrl: RTL and testbench

Initiator-side control for a `mor1kx_simple_dpram_sclk` instance. It turns the RAM's raw read/write ports into a first-word-fall-through FIFO with valid/ready handshakes on both sides. It owns the write and read pointers and the occupancy count, and drives `raddr/re/waddr/we/din`. It consumes `dout` and presents it through an output slot. Used wherever a RAM-backed queue is needed, such as store and trace buffers.

---
 rtl/mor1kx_dpram_fifo_ctrl.sv | 131 +++++++++++++
 tb/tb_mor1kx_dpram_fifo_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller wrapped around a simple single-clock dual-port RAM.
// Owns the write/read pointers and RAM occupancy; the RAM's registered dout acts as the output slot.
module mor1kx_dpram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic [ADDR_WIDTH-1:0] ram_waddr_o,
    output logic                  ram_we_o,
    output logic [DATA_WIDTH-1:0] ram_din_o,
    output logic [ADDR_WIDTH-1:0] ram_raddr_o,
    output logic                  ram_re_o,
    input  logic [DATA_WIDTH-1:0] ram_dout_i
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic                  out_valid_q, out_valid_d;

    logic                  in_ready_s;
    logic                  push_s;
    logic                  pop_ram_s;
    logic [ADDR_WIDTH:0]   level_s;

    // Handshake qualification; a read only targets entries committed on an earlier edge.
    always_comb begin
        in_ready_s = 1'b0;
        push_s     = 1'b0;
        pop_ram_s  = 1'b0;
        if (!rst && !flush_i) begin
            in_ready_s = (ram_cnt_q != CNT_FULL);
            push_s     = in_valid_i && in_ready_s;
            pop_ram_s  = (ram_cnt_q != CNT_ZERO) && (!out_valid_q || out_ready_i);
        end else begin
            in_ready_s = 1'b0;
            push_s     = 1'b0;
            pop_ram_s  = 1'b0;
        end
    end

    // Next-state for pointers, occupancy and the output slot flag.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        ram_cnt_d   = ram_cnt_q;
        out_valid_d = out_valid_q;
        if (flush_i) begin
            wptr_d      = PTR_ZERO;
            rptr_d      = PTR_ZERO;
            ram_cnt_d   = CNT_ZERO;
            out_valid_d = 1'b0;
        end else begin
            if (push_s) begin
                wptr_d = wptr_q + PTR_ONE;
            end else begin
                wptr_d = wptr_q;
            end
            if (pop_ram_s) begin
                rptr_d = rptr_q + PTR_ONE;
            end else begin
                rptr_d = rptr_q;
            end
            case ({push_s, pop_ram_s})
                2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
                2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
                default: ram_cnt_d = ram_cnt_q;
            endcase
            // The slot refills from RAM whenever a read is issued, even while being consumed.
            if (pop_ram_s) begin
                out_valid_d = 1'b1;
            end else if (out_ready_i) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= PTR_ZERO;
            rptr_q      <= PTR_ZERO;
            ram_cnt_q   <= CNT_ZERO;
            out_valid_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            ram_cnt_q   <= ram_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Occupancy seen by the outside: RAM entries plus the output slot, forced to zero in reset.
    always_comb begin
        level_s = CNT_ZERO;
        if (rst) begin
            level_s = CNT_ZERO;
        end else begin
            level_s = ram_cnt_q + {{ADDR_WIDTH{1'b0}}, out_valid_q};
        end
    end

    assign in_ready_o  = in_ready_s;
    assign ram_we_o    = push_s;
    assign ram_waddr_o = wptr_q;
    assign ram_din_o   = in_data_i;
    assign ram_re_o    = pop_ram_s;
    assign ram_raddr_o = rptr_q;
    assign out_valid_o = out_valid_q && !rst;
    assign out_data_o  = ram_dout_i;
    assign level_o     = level_s;

endmodule

// File: tb/tb_mor1kx_dpram_fifo_ctrl.sv
// Self-checking bench: vector table for latency/fill/drain, scoreboard for data ordering,
// hand sequences for streaming, stalls, flush and reset. Includes a behavioural single-clock RAM.
module tb_mor1kx_dpram_fifo_ctrl;

    localparam int AW = 2;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          flush_i;
    logic          in_valid_i;
    logic [DW-1:0] in_data_i;
    logic          in_ready_o;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic          out_ready_i;
    logic [AW:0]   level_o;
    logic [AW-1:0] ram_waddr_o;
    logic          ram_we_o;
    logic [DW-1:0] ram_din_o;
    logic [AW-1:0] ram_raddr_o;
    logic          ram_re_o;
    logic [DW-1:0] ram_dout_i;

    mor1kx_dpram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
        .level_o(level_o),
        .ram_waddr_o(ram_waddr_o), .ram_we_o(ram_we_o), .ram_din_o(ram_din_o),
        .ram_raddr_o(ram_raddr_o), .ram_re_o(ram_re_o), .ram_dout_i(ram_dout_i)
    );

    // Behavioural simple dual-port RAM: registered read, dout held while re is low.
    logic [DW-1:0] mem [4];
    always @(posedge clk) begin
        if (ram_we_o) mem[ram_waddr_o] <= ram_din_o;
        if (ram_re_o) ram_dout_i <= mem[ram_raddr_o];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_pops = 0;
    logic [DW-1:0] sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Wait to the falling edge and update the scoreboard from the observed handshakes.
    task automatic sample();
        @(negedge clk);
        if (out_valid_o && out_ready_i) begin
            n_pops++;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got %0h, expected no output", out_data_o);
            end else begin
                chk("sb_data", {24'h0, out_data_o}, {24'h0, sb.pop_front()});
            end
        end
        if (in_valid_i && in_ready_o) sb.push_back(in_data_i);
        if (flush_i || rst) sb.delete();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          r, f, iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          eir, ewe, ere, eov;
        logic [AW:0]   elv;
    } vec_t;

    function automatic vec_t mk(logic r, logic f, logic iv, logic [DW-1:0] d, logic ordy,
                                logic eir, logic ewe, logic ere, logic eov, logic [AW:0] elv);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.d = d; v.ordy = ordy;
        v.eir = eir; v.ewe = ewe; v.ere = ere; v.eov = eov; v.elv = elv;
        return v;
    endfunction

    vec_t vt [19];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] held;
        logic          stalled;
        logic          blocked;
        int            k;
        int            base;

        //          r     f     iv    data   ordy  ir    we    re    ov    lvl
        vt[0]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        vt[1]  = mk(1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        vt[2]  = mk(1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        vt[3]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1);
        vt[4]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
        vt[5]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        vt[6]  = mk(1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        vt[7]  = mk(1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1);
        vt[8]  = mk(1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2);
        vt[9]  = mk(1'b0, 1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd3);
        vt[10] = mk(1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4);
        vt[11] = mk(1'b0, 1'b0, 1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5);
        vt[12] = mk(1'b0, 1'b0, 1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5);
        vt[13] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5);
        vt[14] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4);
        vt[15] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3);
        vt[16] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2);
        vt[17] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
        vt[18] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = 8'h00; out_ready_i = 1'b0;

        // Reset, latency, fill and drain from the vector table.
        for (int i = 0; i < 19; i++) begin
            rst = vt[i].r; flush_i = vt[i].f; in_valid_i = vt[i].iv;
            in_data_i = vt[i].d; out_ready_i = vt[i].ordy;
            sample();
            chk($sformatf("v%0d_in_ready", i),  {31'h0, in_ready_o},  {31'h0, vt[i].eir});
            chk($sformatf("v%0d_we", i),        {31'h0, ram_we_o},    {31'h0, vt[i].ewe});
            chk($sformatf("v%0d_re", i),        {31'h0, ram_re_o},    {31'h0, vt[i].ere});
            chk($sformatf("v%0d_out_valid", i), {31'h0, out_valid_o}, {31'h0, vt[i].eov});
            chk($sformatf("v%0d_level", i),     {29'h0, level_o},     {29'h0, vt[i].elv});
            adv();
        end
        chk("table_sb_empty", sb.size(), 0);

        // Streaming 20 entries with both sides always ready, pointers wrap several times.
        base = n_pops;
        k = 0;
        in_valid_i = 1'b1; out_ready_i = 1'b1;
        for (int c = 0; c < 40 && k < 20; c++) begin
            in_data_i = 8'h10 + 8'(k);
            sample();
            chk("stream_level_le2", {31'h0, (level_o <= 3'd2)}, 32'h1);
            chk("stream_in_ready", {31'h0, in_ready_o}, 32'h1);
            if (in_ready_o) k++;
            adv();
        end
        in_valid_i = 1'b0;
        for (int c = 0; c < 10 && (sb.size() > 0 || out_valid_o); c++) begin
            sample();
            adv();
        end
        chk("stream_pushes", k, 20);
        chk("stream_outputs", n_pops - base, 20);

        // Random stalls on both sides; the head must hold while stalled.
        stalled = 1'b0; blocked = 1'b0; held = 8'h00;
        for (int c = 0; c < 80; c++) begin
            if (!blocked) begin
                in_valid_i = 1'($urandom_range(0, 1));
                in_data_i  = 8'($urandom_range(0, 255));
            end
            out_ready_i = 1'($urandom_range(0, 1));
            sample();
            if (stalled) begin
                chk("stall_valid_held", {31'h0, out_valid_o}, 32'h1);
                chk("stall_data_held", {24'h0, out_data_o}, {24'h0, held});
            end
            stalled = out_valid_o && !out_ready_i;
            held    = out_data_o;
            blocked = in_valid_i && !in_ready_o;
            adv();
        end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        for (int c = 0; c < 20 && (sb.size() > 0 || out_valid_o); c++) begin
            sample();
            adv();
        end
        chk("stall_drained", sb.size(), 0);

        // Flush then reset, each with three entries held and a concurrent push of 0x77.
        for (int pass = 0; pass < 2; pass++) begin
            out_ready_i = 1'b0;
            for (int j = 0; j < 3; j++) begin
                in_valid_i = 1'b1; in_data_i = 8'hAA + 8'(j * 17);
                sample();
                adv();
            end
            in_valid_i = 1'b0;
            sample();
            chk($sformatf("p%0d_level3", pass), {29'h0, level_o}, 32'h3);
            adv();
            in_valid_i = 1'b1; in_data_i = 8'h77;
            if (pass == 0) flush_i = 1'b1; else rst = 1'b1;
            sample();
            chk($sformatf("p%0d_in_ready", pass), {31'h0, in_ready_o}, 32'h0);
            chk($sformatf("p%0d_we", pass), {31'h0, ram_we_o}, 32'h0);
            chk($sformatf("p%0d_re", pass), {31'h0, ram_re_o}, 32'h0);
            if (pass == 0) begin
                chk("flush_valid_kept", {31'h0, out_valid_o}, 32'h1);
            end else begin
                chk("rst_valid", {31'h0, out_valid_o}, 32'h0);
                chk("rst_level", {29'h0, level_o}, 32'h0);
            end
            adv();
            flush_i = 1'b0; rst = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
            sample();
            chk($sformatf("p%0d_after_level", pass), {29'h0, level_o}, 32'h0);
            chk($sformatf("p%0d_after_valid", pass), {31'h0, out_valid_o}, 32'h0);
            adv();
            for (int c = 0; c < 5; c++) begin
                sample();
                chk($sformatf("p%0d_no_output", pass), {31'h0, out_valid_o}, 32'h0);
                adv();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
